// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared definitions for the GPR write-back arbiter.
//
// Holds the FSM state encoding, the requester index constants and the
// fixed-priority search order used when round-robin arbitration is not built.
// Optional feature macro: WB_ARB_RR_EN (consumed by wb_pick).
package gpr_wb_pkg;

    // State encodings kept as plain constants so legacy code can compare
    // against them; the enum below names the same encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_REL  = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_ACK_REL = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_REQ  = ST_WR_REQ,
        WR_REL  = ST_WR_REL,
        ACK     = ST_ACK,
        ACK_REL = ST_ACK_REL
    } wb_state_t;

    // Requester slots on the write-back port.
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_BR   = 2;

    // Fixed-priority order, highest first: load, then ALU, then branch-link.
    localparam int N_FIXED = 3;
    localparam int FIXED_ORDER [N_FIXED] = '{REQ_LOAD, REQ_ALU, REQ_BR};

    // Maps a search rank to a requester index; ranks beyond the named
    // requesters fall back to ascending index order.
    function automatic int fixed_rank_to_req(input int rank);
        if (rank < N_FIXED) begin
            return FIXED_ORDER[rank];
        end
        return rank;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bus bundle for the GPR write-back arbiter.
//
// Requester side: req_i / ack_o four-phase pair per requester, plus the
// packed destination index (rd_i) and write data (data_i), slice k for
// requester k.  GPR side: gpr_req_o / gpr_ack_i four-phase pair with the
// latched gpr_rd_o / gpr_data_o.  Status: grant_o (one-hot owner), busy_o.
// Modport slave is the arbiter's view; modport master is the environment's.
interface gpr_wb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        ack_o;
    logic [N_REQ*ADDR_W-1:0] rd_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic                    gpr_req_o;
    logic                    gpr_ack_i;
    logic [ADDR_W-1:0]       gpr_rd_o;
    logic [DATA_W-1:0]       gpr_data_o;
    logic [N_REQ-1:0]        grant_o;
    logic                    busy_o;

    modport slave (
        input  req_i, rd_i, data_i, gpr_ack_i,
        output ack_o, gpr_req_o, gpr_rd_o, gpr_data_o, grant_o, busy_o
    );

    modport master (
        output req_i, rd_i, data_i, gpr_ack_i,
        input  ack_o, gpr_req_o, gpr_rd_o, gpr_data_o, grant_o, busy_o
    );

endinterface

// File: rtl/gpr_wb_arbiter_wb_pick.sv
// Combinational winner picker for the GPR write-back arbiter.
//
// Ports: req   - pending request vector
//        last  - index of the most recently granted requester
//        win   - selected requester index (0 when nothing pending)
//        valid - at least one request pending
// Macro WB_ARB_RR_EN: when defined, round-robin search starting after
// 'last'; otherwise fixed priority load > ALU > branch and 'last' is ignored.
module wb_pick
    import gpr_wb_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] win,
    output logic             valid
);

    int cand;

`ifndef WB_ARB_RR_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

    // Walk the candidates in search order and keep the first pending one.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef WB_ARB_RR_EN
            cand = (int'(last) + 1 + k) % N_REQ;
`else
            cand = fixed_rank_to_req(k);
`endif
            if (!valid && cand < N_REQ && req[IDX_W'(cand)]) begin
                valid = 1'b1;
                win   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: shares the single GPR write port between the ALU,
// load and branch-link result paths with a sequenced four-phase handshake on
// both sides.  Destination and data are latched at grant so a requester may
// change its inputs once granted; writes to x0 skip the GPR handshake.
//
// Ports: clk   - rising-edge clock
//        reset - asynchronous, active-low
//        bus   - gpr_wb_arbiter_if.slave (requester and GPR handshakes,
//                grant_o / busy_o status)
// All bus outputs are registered.
// Macro WB_ARB_RR_EN selects round-robin instead of fixed priority.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter  int N_REQ  = 3,
    parameter  int ADDR_W = 5,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic           clk,
    input logic           reset,
    gpr_wb_arbiter_if.slave bus
);

    logic [2:0]        state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  owner;
    logic [N_REQ-1:0]  ack_q;
    logic [N_REQ-1:0]  grant_q;
    logic              gpr_req_q;
    logic              busy_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;

    logic [IDX_W-1:0]  pick_win;
    logic              pick_valid;
    logic [ADDR_W-1:0] rd_sel;
    logic [DATA_W-1:0] data_sel;

    // Requesters already holding an acknowledge are never re-picked.
    wb_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_i & ~ack_q),
        .last  (last),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Slice out the winner's destination and data for latching at grant.
    assign rd_sel   = bus.rd_i[int'(pick_win)*ADDR_W +: ADDR_W];
    assign data_sel = bus.data_i[int'(pick_win)*DATA_W +: DATA_W];

    // Handshake sequencer: every output is driven from a register updated on
    // the transition into the state that owns it, so outputs track the state
    // without a combinational path from the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            last      <= IDX_W'(N_REQ - 1);
            owner     <= '0;
            ack_q     <= '0;
            grant_q   <= '0;
            gpr_req_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_win;
                        last    <= pick_win;
                        grant_q <= N_REQ'(1) << pick_win;
                        rd_q    <= rd_sel;
                        data_q  <= data_sel;
                        busy_q  <= 1'b1;
                        if (rd_sel == '0) begin
                            state <= ST_ACK;
                            ack_q <= N_REQ'(1) << pick_win;
                        end else begin
                            state     <= ST_WR_REQ;
                            gpr_req_q <= 1'b1;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (bus.gpr_ack_i) begin
                        state     <= ST_WR_REL;
                        gpr_req_q <= 1'b0;
                    end
                end
                ST_WR_REL: begin
                    if (!bus.gpr_ack_i) begin
                        state <= ST_ACK;
                        ack_q <= grant_q;
                    end
                end
                ST_ACK: begin
                    if (!bus.req_i[owner]) begin
                        state   <= ST_ACK_REL;
                        ack_q   <= '0;
                        grant_q <= '0;
                    end
                end
                ST_ACK_REL: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    ack_q     <= '0;
                    grant_q   <= '0;
                    gpr_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_o      = ack_q;
    assign bus.gpr_req_o  = gpr_req_q;
    assign bus.gpr_rd_o   = rd_q;
    assign bus.gpr_data_o = data_q;
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (both builds of
// WB_ARB_RR_EN).  Scripted cycles for single transactions, plus simple
// requester / GPR responders for the multi-requester orderings.
module tb_gpr_wb_arbiter;

    logic clk;
    logic reset;

    gpr_wb_arbiter_if #(.N_REQ(3), .ADDR_W(5), .DATA_W(32)) bus ();

    gpr_wb_arbiter #(.N_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef WB_ARB_RR_EN
    localparam int EXP_SIM    [3] = '{0, 1, 2};
    localparam int EXP_STARVE [4] = '{0, 1, 0, 1};
`else
    localparam int EXP_SIM    [3] = '{1, 0, 2};
    localparam int EXP_STARVE [4] = '{1, 1, 1, 1};
`endif

    int compared;
    int mismatched;

    bit auto_gpr;
    bit auto_req;
    int remaining [3];
    int hold      [3];
    int wait_cnt  [3];
    int txn       [3];

    int          grant_log [$];
    logic [31:0] data_log  [$];
    logic [2:0]  prev_grant;
    logic        prev_gpr_req;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_to_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [2:0] req, input logic [14:0] rd, input logic [95:0] data);
        bus.req_i  = req;
        bus.rd_i   = rd;
        bus.data_i = data;
    endtask

    // One clock: sample just after the edge, log grants and GPR writes, then
    // let the optional responders react for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.grant_o != 3'b000 && prev_grant == 3'b000) grant_log.push_back(onehot_to_idx(bus.grant_o));
        if (bus.gpr_req_o && !prev_gpr_req) data_log.push_back(bus.gpr_data_o);
        prev_grant   = bus.grant_o;
        prev_gpr_req = bus.gpr_req_o;
        if (auto_gpr) bus.gpr_ack_i = bus.gpr_req_o;
        if (auto_req) begin
            for (int k = 0; k < 3; k++) begin
                if (bus.req_i[k]) begin
                    if (bus.ack_o[k]) begin
                        if (wait_cnt[k] >= hold[k]) begin
                            bus.req_i[k] = 1'b0;
                            wait_cnt[k]  = 0;
                            if (remaining[k] > 0) remaining[k]--;
                        end else begin
                            wait_cnt[k]++;
                        end
                    end
                end else if (!bus.ack_o[k] && remaining[k] > 0) begin
                    bus.req_i[k]            = 1'b1;
                    bus.rd_i[k*5 +: 5]      = 5'(k + 1);
                    bus.data_i[k*32 +: 32]  = {8'hA0, 8'(k), 16'(txn[k])};
                    txn[k]++;
                end
            end
        end
    endtask

    task automatic applyReset();
        auto_gpr = 1'b0;
        auto_req = 1'b0;
        applyStimulus(3'b000, 15'h0, 96'h0);
        bus.gpr_ack_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            remaining[k] = 0;
            hold[k]      = 0;
            wait_cnt[k]  = 0;
            txn[k]       = 0;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b1;
        prev_grant   = 3'b000;
        prev_gpr_req = 1'b0;
        grant_log.delete();
        data_log.delete();
    endtask

    initial begin
        int  cyc;
        int  phase;
        int  ack_cycles;
        int  overlap;
        int  gap;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;

        // Reset state.
        applyReset();
        checkOutput("rst_ack",     32'(bus.ack_o), 32'h0);
        checkOutput("rst_gpr_req", 32'(bus.gpr_req_o), 32'h0);
        checkOutput("rst_gpr_rd",  32'(bus.gpr_rd_o), 32'h0);
        checkOutput("rst_gpr_data", bus.gpr_data_o, 32'h0);
        checkOutput("rst_grant",   32'(bus.grant_o), 32'h0);
        checkOutput("rst_busy",    32'(bus.busy_o), 32'h0);

        // Single ALU write, GPR acknowledges after two cycles.
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF});
        step();
        checkOutput("t1_gpr_req",  32'(bus.gpr_req_o), 32'h1);
        checkOutput("t1_grant",    32'(bus.grant_o), 32'h1);
        checkOutput("t1_rd",       32'(bus.gpr_rd_o), 32'h5);
        checkOutput("t1_data",     bus.gpr_data_o, 32'hDEADBEEF);
        checkOutput("t1_ack_early", 32'(bus.ack_o), 32'h0);
        checkOutput("t1_busy",     32'(bus.busy_o), 32'h1);
        applyStimulus(3'b001, 15'h7FFF, {96{1'b1}});
        step();
        checkOutput("t1_gpr_req_hold", 32'(bus.gpr_req_o), 32'h1);
        checkOutput("t1_data_latched", bus.gpr_data_o, 32'hDEADBEEF);
        bus.gpr_ack_i = 1'b1;
        step();
        checkOutput("t1_gpr_req_rel", 32'(bus.gpr_req_o), 32'h0);
        step();
        checkOutput("t1_ack_wait_gpr", 32'(bus.ack_o), 32'h0);
        bus.gpr_ack_i = 1'b0;
        step();
        checkOutput("t1_ack", 32'(bus.ack_o), 32'h1);
        checkOutput("t1_rd_at_ack", 32'(bus.gpr_rd_o), 32'h5);
        step();
        checkOutput("t1_ack_held", 32'(bus.ack_o), 32'h1);
        bus.req_i = 3'b000;
        step();
        checkOutput("t1_ack_rel",   32'(bus.ack_o), 32'h0);
        checkOutput("t1_grant_rel", 32'(bus.grant_o), 32'h0);
        checkOutput("t1_busy_rel",  32'(bus.busy_o), 32'h1);
        step();
        checkOutput("t1_idle_busy", 32'(bus.busy_o), 32'h0);
        checkOutput("t1_idle_rd",   32'(bus.gpr_rd_o), 32'h5);
        checkOutput("t1_idle_data", bus.gpr_data_o, 32'hDEADBEEF);

        // Load write to x0: no GPR handshake, acknowledge straight away.
        applyReset();
        applyStimulus(3'b010, 15'h0, {32'h0, 32'h12345678, 32'h0});
        step();
        checkOutput("x0_ack",     32'(bus.ack_o), 32'h2);
        checkOutput("x0_grant",   32'(bus.grant_o), 32'h2);
        checkOutput("x0_gpr_req", 32'(bus.gpr_req_o), 32'h0);
        bus.gpr_ack_i = 1'b1;
        step();
        checkOutput("x0_gpr_req_2", 32'(bus.gpr_req_o), 32'h0);
        checkOutput("x0_ack_held",  32'(bus.ack_o), 32'h2);
        bus.gpr_ack_i = 1'b0;
        bus.req_i     = 3'b000;
        step();
        checkOutput("x0_ack_rel", 32'(bus.ack_o), 32'h0);
        step();
        checkOutput("x0_idle_busy", 32'(bus.busy_o), 32'h0);

        // Three simultaneous requests.
        applyReset();
        auto_gpr = 1'b1;
        auto_req = 1'b1;
        for (int k = 0; k < 3; k++) remaining[k] = 1;
        for (cyc = 0; cyc < 100; cyc++) begin
            step();
            if (grant_log.size() == 3 && !bus.busy_o) break;
        end
        checkOutput("sim_done", 32'(cyc < 100), 32'h1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("sim_order%0d", i),
                        32'((i < grant_log.size()) ? grant_log[i] : 99), 32'(EXP_SIM[i]));
            checkOutput($sformatf("sim_data%0d", i),
                        (i < data_log.size()) ? data_log[i] : 32'hFFFFFFFF,
                        {8'hA0, 8'(EXP_SIM[i]), 16'h0});
        end

        // Requesters 0 and 1 re-request continuously.
        applyReset();
        auto_gpr     = 1'b1;
        auto_req     = 1'b1;
        remaining[0] = 4;
        remaining[1] = 4;
        for (cyc = 0; cyc < 100; cyc++) begin
            step();
            if (grant_log.size() >= 4) break;
        end
        checkOutput("starve_done", 32'(cyc < 100), 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("starve_order%0d", i),
                        32'((i < grant_log.size()) ? grant_log[i] : 99), 32'(EXP_STARVE[i]));
        end
        remaining[0] = 0;
        remaining[1] = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            step();
            if (!bus.busy_o && bus.req_i == 3'b000) break;
        end
        checkOutput("starve_drain", 32'(cyc < 100), 32'h1);

        // Reset while the GPR request is up.
        applyReset();
        applyStimulus(3'b101, {5'd9, 5'd0, 5'd7}, {32'h22222222, 32'h0, 32'h11111111});
        step();
        checkOutput("rw_gpr_req", 32'(bus.gpr_req_o), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rw_ack",      32'(bus.ack_o), 32'h0);
        checkOutput("rw_gpr_req0", 32'(bus.gpr_req_o), 32'h0);
        checkOutput("rw_grant",    32'(bus.grant_o), 32'h0);
        checkOutput("rw_busy",     32'(bus.busy_o), 32'h0);
        checkOutput("rw_rd",       32'(bus.gpr_rd_o), 32'h0);
        checkOutput("rw_data",     bus.gpr_data_o, 32'h0);
        step();
        reset = 1'b1;
        step();
        checkOutput("rw_regrant",    32'(bus.grant_o), 32'h1);
        checkOutput("rw_regrant_rd", 32'(bus.gpr_rd_o), 32'h7);
        checkOutput("rw_no_ack",     32'(bus.ack_o), 32'h0);

        // Slow branch-link requester holds req after its acknowledge.
        applyReset();
        auto_gpr     = 1'b1;
        auto_req     = 1'b1;
        hold[2]      = 5;
        remaining[2] = 1;
        for (cyc = 0; cyc < 50; cyc++) begin
            step();
            if (bus.grant_o == 3'b100) break;
        end
        checkOutput("slow_grant", 32'(bus.grant_o), 32'h4);
        remaining[0] = 1;
        phase      = 0;
        ack_cycles = 0;
        overlap    = 0;
        gap        = 0;
        for (cyc = 0; cyc < 100 && phase < 3; cyc++) begin
            step();
            case (phase)
                0: if (bus.ack_o[2]) begin
                       ack_cycles++;
                       phase = 1;
                   end
                1: if (bus.ack_o[2]) begin
                       ack_cycles++;
                       if (bus.grant_o != 3'b100 || bus.ack_o[0]) overlap++;
                   end else begin
                       gap   = 0;
                       phase = 2;
                   end
                default: begin
                    gap++;
                    if (bus.grant_o == 3'b001) phase = 3;
                end
            endcase
        end
        checkOutput("slow_done",    32'(phase), 32'h3);
        checkOutput("slow_ack_len", 32'(ack_cycles), 32'h6);
        checkOutput("slow_overlap", 32'(overlap), 32'h0);
        checkOutput("slow_gap",     32'(gap), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
